traffic_light_monitor: RTL

//  Passive checker on the NS/EW light buses driven by the traffic light controller.

---
 rtl/traffic_light_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker of the NS/EW lamp buses: decodes each ticked sample into a phase
// and flags illegal, conflicting, out-of-order and mistimed phases.
// Latency: one clk edge per tick sample. Backpressure: none; it only observes.
module traffic_light_monitor #(
    parameter int GREEN_TICKS  = 6,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 2,
    parameter int TOL          = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count,
    output logic [2:0] phase,
    output logic       synced,
    output logic [7:0] cycle_count
);

    typedef enum logic [2:0] {
        P0    = 3'd0,
        P1    = 3'd1,
        P2    = 3'd2,
        P3    = 3'd3,
        P4    = 3'd4,
        P5    = 3'd5,
        P_UNK = 3'd7
    } phase_t;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_ILLEGAL  = 3'd1;
    localparam logic [2:0] C_CONFLICT = 3'd2;
    localparam logic [2:0] C_BADSEQ   = 3'd3;
    localparam logic [2:0] C_SHORT    = 3'd4;
    localparam logic [2:0] C_LONG     = 3'd5;

    phase_t     phase_q, phase_n, obs, succ;
    logic [3:0] dwell_q, dwell_n;
    logic       long_q, long_n;
    logic       synced_n;
    logic       cyc_inc;
    logic [2:0] code_n;
    logic       ns_ok, ew_ok, ns_red, ew_red;

    function automatic int exp_dwell(input phase_t p);
        case (p)
            P0, P3:  exp_dwell = GREEN_TICKS;
            P1, P4:  exp_dwell = YELLOW_TICKS;
            default: exp_dwell = ALLRED_TICKS;
        endcase
    endfunction

    always_comb begin
        ns_ok  = (ns_light == 3'b001) || (ns_light == 3'b010) || (ns_light == 3'b100);
        ew_ok  = (ew_light == 3'b001) || (ew_light == 3'b010) || (ew_light == 3'b100);
        ns_red = (ns_light == 3'b100);
        ew_red = (ew_light == 3'b100);
        succ   = (phase_q == P5) ? P0 : phase_t'(phase_q + 3'd1);

        // All-red is ambiguous; only a synced tracker coming out of EW traffic calls it P5.
        if (ew_red && ns_light == 3'b001)      obs = P0;
        else if (ew_red && ns_light == 3'b010) obs = P1;
        else if (ns_red && ew_light == 3'b001) obs = P3;
        else if (ns_red && ew_light == 3'b010) obs = P4;
        else if (synced && (phase_q == P4 || phase_q == P5)) obs = P5;
        else                                    obs = P2;
    end

    always_comb begin
        code_n   = C_NONE;
        phase_n  = phase_q;
        dwell_n  = dwell_q;
        synced_n = synced;
        long_n   = long_q;
        cyc_inc  = 1'b0;
        if (tick) begin
            if (!(ns_ok && ew_ok) || (!ns_red && !ew_red)) begin
                code_n   = (!(ns_ok && ew_ok)) ? C_ILLEGAL : C_CONFLICT;
                phase_n  = P_UNK;
                dwell_n  = 4'd0;
                synced_n = 1'b0;
                long_n   = 1'b0;
            end else if (phase_q == P_UNK) begin
                phase_n  = obs;
                dwell_n  = 4'd1;
                synced_n = 1'b0;
                long_n   = 1'b0;
            end else if (obs == phase_q) begin
                dwell_n = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;
                if (synced && !long_q &&
                    int'(dwell_n) >= exp_dwell(phase_q) + TOL + 1) begin
                    code_n = C_LONG;
                    long_n = 1'b1;
                end
            end else begin
                if (obs == succ) begin
                    if (synced && int'(dwell_q) < exp_dwell(phase_q) - TOL)
                        code_n = C_SHORT;
                    synced_n = 1'b1;
                end else begin
                    if (synced)
                        code_n = C_BADSEQ;
                    synced_n = 1'b0;
                end
                cyc_inc = (phase_q == P5) && (obs == P0);
                phase_n = obs;
                dwell_n = 4'd1;
                long_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= P_UNK;
            dwell_q     <= 4'd0;
            long_q      <= 1'b0;
            synced      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            fault_count <= 8'd0;
            cycle_count <= 8'd0;
        end else begin
            if (cyc_inc)
                cycle_count <= cycle_count + 8'd1;
            if (clear) begin
                // A fault seen on the clearing sample survives as the first new fault.
                phase_q     <= P_UNK;
                dwell_q     <= 4'd0;
                long_q      <= 1'b0;
                synced      <= 1'b0;
                fault       <= (code_n != C_NONE);
                fault_code  <= code_n;
                fault_count <= (code_n != C_NONE) ? 8'd1 : 8'd0;
            end else begin
                phase_q <= phase_n;
                dwell_q <= dwell_n;
                long_q  <= long_n;
                synced  <= synced_n;
                if (code_n != C_NONE) begin
                    fault <= 1'b1;
                    if (!fault)
                        fault_code <= code_n;
                    if (fault_count != 8'd255)
                        fault_count <= fault_count + 8'd1;
                end
            end
        end
    end

    assign phase = phase_q;

endmodule
